// File: rtl/pipeline_idr_stage_elastic.sv
// pipeline_idr_stage_elastic: elastic decode->execute register-read stage with operand forwarding and 2-entry skid buffer
// Optional feature macro: IDR_HOLD_REFRESH_EN (held entries re-snoop the forward buses every cycle)
module pipeline_idr_stage_elastic #(
    parameter int XLEN    = 64,
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 3,
    parameter int CTRL_W  = 32
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_flush,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    input  logic [XLEN-1:0]           i_in_pc,
    input  logic [NUM_SRC*5-1:0]      i_in_rs,
    input  logic [NUM_SRC-1:0]        i_in_rs_used,
    input  logic [4:0]                i_in_rd,
    input  logic [XLEN-1:0]           i_in_imm,
    input  logic [CTRL_W-1:0]         i_in_ctrl,
    input  logic [NUM_SRC*XLEN-1:0]   i_rf_rdata,
    input  logic [NUM_FWD-1:0]        i_fwd_en,
    input  logic [NUM_FWD*5-1:0]      i_fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0]   i_fwd_data,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [XLEN-1:0]           o_out_pc,
    output logic [4:0]                o_out_rd,
    output logic [XLEN-1:0]           o_out_imm,
    output logic [CTRL_W-1:0]         o_out_ctrl,
    output logic [NUM_SRC*5-1:0]      o_out_rs,
    output logic [NUM_SRC*XLEN-1:0]   o_out_rs_data
);
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    typedef struct packed {
        logic [NUM_SRC-1:0]      used;
        logic [NUM_SRC*5-1:0]    rs;
        logic [4:0]              rd;
        logic [XLEN-1:0]         pc;
        logic [XLEN-1:0]         imm;
        logic [CTRL_W-1:0]       ctrl;
        logic [NUM_SRC*XLEN-1:0] data;
    } entry_t;

    state_t r_state, w_next;
    entry_t r_main, r_skid, w_in, w_main_hold, w_skid_hold;
    logic   w_acc, w_pop;

    // Returns {hit, data}; scanning from the oldest bus down lets the youngest match win.
    // x0 and unused sources never hit.
    function automatic logic [XLEN:0] snoop(input logic [4:0] rs, input logic used);
        logic [XLEN:0] r;
        r = '0;
        if (used && rs != 5'd0)
            for (int k = NUM_FWD - 1; k >= 0; k--)
                if (i_fwd_en[k] && i_fwd_rd[k*5 +: 5] == rs)
                    r = {1'b1, i_fwd_data[k*XLEN +: XLEN]};
        return r;
    endfunction

`ifdef IDR_HOLD_REFRESH_EN
    // Overwrites any operand of a held entry that a forward bus currently writes.
    function automatic entry_t refresh(input entry_t e);
        entry_t r;
        logic [XLEN:0] s;
        r = e;
        for (int i = 0; i < NUM_SRC; i++) begin
            s = snoop(e.rs[i*5 +: 5], e.used[i]);
            if (s[XLEN]) r.data[i*XLEN +: XLEN] = s[XLEN-1:0];
        end
        return r;
    endfunction
`endif

    assign o_in_ready  = (r_state != S_TWO);
    assign o_out_valid = (r_state != S_EMPTY);
    assign w_acc       = i_in_valid & o_in_ready;
    assign w_pop       = o_out_valid & i_out_ready;

    assign o_out_pc      = r_main.pc;
    assign o_out_rd      = r_main.rd;
    assign o_out_imm     = r_main.imm;
    assign o_out_ctrl    = r_main.ctrl;
    assign o_out_rs      = r_main.rs;
    assign o_out_rs_data = r_main.data;

    // Build the incoming entry with resolved operands (x0/unused -> 0, forward, else register file).
    always_comb begin
        logic [XLEN:0] s;
        w_in      = '0;
        w_in.used = i_in_rs_used;
        w_in.rs   = i_in_rs;
        w_in.rd   = i_in_rd;
        w_in.pc   = i_in_pc;
        w_in.imm  = i_in_imm;
        w_in.ctrl = i_in_ctrl;
        for (int i = 0; i < NUM_SRC; i++) begin
            s = snoop(i_in_rs[i*5 +: 5], i_in_rs_used[i]);
            w_in.data[i*XLEN +: XLEN] = s[XLEN] ? s[XLEN-1:0] :
                (i_in_rs_used[i] && i_in_rs[i*5 +: 5] != 5'd0) ? i_rf_rdata[i*XLEN +: XLEN] : '0;
        end
    end

    // Value each held entry keeps when it is not replaced this cycle.
    always_comb begin
`ifdef IDR_HOLD_REFRESH_EN
        w_main_hold = refresh(r_main);
        w_skid_hold = refresh(r_skid);
`else
        w_main_hold = r_main;
        w_skid_hold = r_skid;
`endif
    end

    // Next-state logic; flush empties the stage and drops the same-cycle input.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_EMPTY: w_next = w_acc ? S_ONE : S_EMPTY;
            S_ONE:   w_next = (w_acc && !w_pop) ? S_TWO : (!w_acc && w_pop) ? S_EMPTY : S_ONE;
            S_TWO:   w_next = w_pop ? S_ONE : S_TWO;
            default: w_next = S_EMPTY;
        endcase
        if (i_flush) w_next = S_EMPTY;
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) r_state <= S_EMPTY;
        else          r_state <= w_next;
    end

    // MAIN entry: cleared whenever the stage goes empty so a bubble reads as all-zero.
    always_ff @(posedge i_clk) begin
        if (!i_reset || w_next == S_EMPTY)               r_main <= '0;
        else if (w_acc && (r_state == S_EMPTY || w_pop)) r_main <= w_in;
        else if (r_state == S_TWO && w_pop)              r_main <= w_skid_hold;
        else                                             r_main <= w_main_hold;
    end

    // SKID entry: catches the input when MAIN is stalled, drains into MAIN on pop.
    always_ff @(posedge i_clk) begin
        if (!i_reset || i_flush)                      r_skid <= '0;
        else if (w_acc && r_state == S_ONE && !w_pop) r_skid <= w_in;
        else if (r_state == S_TWO && w_pop)           r_skid <= '0;
        else                                          r_skid <= w_skid_hold;
    end
endmodule

// File: tb/tb_pipeline_idr_stage_elastic.sv
// tb_pipeline_idr_stage_elastic: directed self-checking bench for pipeline_idr_stage_elastic
module tb_pipeline_idr_stage_elastic;
    logic         clk = 1'b0;
    logic         reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [63:0]  in_pc, in_imm, out_pc, out_imm;
    logic [9:0]   in_rs, out_rs;
    logic [1:0]   in_rs_used;
    logic [4:0]   in_rd, out_rd;
    logic [31:0]  in_ctrl, out_ctrl;
    logic [127:0] rf_rdata, out_rs_data;
    logic [2:0]   fwd_en;
    logic [14:0]  fwd_rd;
    logic [191:0] fwd_data;
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    pipeline_idr_stage_elastic dut (
        .i_clk(clk), .i_reset(reset), .i_flush(flush),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_pc(in_pc), .i_in_rs(in_rs), .i_in_rs_used(in_rs_used),
        .i_in_rd(in_rd), .i_in_imm(in_imm), .i_in_ctrl(in_ctrl),
        .i_rf_rdata(rf_rdata), .i_fwd_en(fwd_en), .i_fwd_rd(fwd_rd), .i_fwd_data(fwd_data),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_pc(out_pc), .o_out_rd(out_rd), .o_out_imm(out_imm),
        .o_out_ctrl(out_ctrl), .o_out_rs(out_rs), .o_out_rs_data(out_rs_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [63:0] pc);
        in_valid = v;
        in_pc    = pc;
        in_imm   = pc + 64'h1000;
        in_ctrl  = pc[31:0] ^ 32'hA5A5_0000;
        in_rd    = pc[6:2];
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        offer(1'b1, 64'h40);
        in_rs = {5'd2, 5'd1}; in_rs_used = 2'b11;
        rf_rdata = {64'h11, 64'h11};
        fwd_en = 3'b000; fwd_rd = '0; fwd_data = '0;
        tick(); tick();
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_pc", out_pc, 64'd0);
        chk("rst_data", out_rs_data[63:0], 64'd0);
        reset = 1'b1;

        // back-to-back: one cycle latency, in order, never stalls
        for (int k = 0; k < 4; k++) begin
            offer(1'b1, 64'h100 + 64'(4 * k));
            tick();
            chk("b2b_valid", {63'd0, out_valid}, 64'd1);
            chk("b2b_pc", out_pc, 64'h100 + 64'(4 * k));
            chk("b2b_ready", {63'd0, in_ready}, 64'd1);
            chk("b2b_rs0", out_rs_data[63:0], 64'h11);
        end
        chk("b2b_imm", out_imm, 64'h110c);
        chk("b2b_ctrl", {32'd0, out_ctrl}, 64'hA5A5_010C);
        chk("b2b_rd", {59'd0, out_rd}, 64'd3);
        chk("b2b_rs", {54'd0, out_rs}, 64'h041);
        offer(1'b0, 64'h0);
        tick();
        chk("b2b_drain", {63'd0, out_valid}, 64'd0);
        chk("b2b_bubble", out_pc, 64'd0);

        // skid: fill both entries, extra offer refused, drain in order
        out_ready = 1'b0;
        offer(1'b1, 64'h200); tick();
        chk("skid_ready1", {63'd0, in_ready}, 64'd1);
        offer(1'b1, 64'h204); tick();
        chk("skid_ready2", {63'd0, in_ready}, 64'd0);
        chk("skid_headA", out_pc, 64'h200);
        offer(1'b1, 64'h208); tick();
        chk("skid_stall", out_pc, 64'h200);
        chk("skid_full", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1; offer(1'b0, 64'h0); tick();
        chk("skid_popB", out_pc, 64'h204);
        chk("skid_validB", {63'd0, out_valid}, 64'd1);
        chk("skid_ready3", {63'd0, in_ready}, 64'd1);
        tick();
        chk("skid_empty", {63'd0, out_valid}, 64'd0);

        // forwarding priority and x0 suppression
        in_rs = {5'd0, 5'd5}; in_rs_used = 2'b11; rf_rdata = {64'h99, 64'h11};
        fwd_en = 3'b111; fwd_rd = {5'd5, 5'd5, 5'd5};
        fwd_data = {64'hC, 64'hB, 64'hA};
        offer(1'b1, 64'h300); tick();
        chk("fwd_prio0", out_rs_data[63:0], 64'hA);
        chk("fwd_x0_rs2", out_rs_data[127:64], 64'd0);
        fwd_en = 3'b110; offer(1'b1, 64'h304); tick();
        chk("fwd_prio1", out_rs_data[63:0], 64'hB);
        fwd_en = 3'b111; fwd_rd = '0; in_rs = {5'd3, 5'd0};
        offer(1'b1, 64'h308); tick();
        chk("fwd_x0", out_rs_data[63:0], 64'd0);
        chk("fwd_miss_rf", out_rs_data[127:64], 64'h99);
        fwd_en = 3'b000; in_rs = {5'd4, 5'd6}; in_rs_used = 2'b01;
        rf_rdata = {64'hFF, 64'h22};
        offer(1'b1, 64'h30c); tick();
        chk("unused_rs2", out_rs_data[127:64], 64'd0);
        chk("used_rs1", out_rs_data[63:0], 64'h22);
        offer(1'b0, 64'h0); tick();

        // flush while full drops the same-cycle input
        out_ready = 1'b0; in_rs_used = 2'b11;
        offer(1'b1, 64'h400); tick();
        offer(1'b1, 64'h404); tick();
        chk("fl_full", {63'd0, in_ready}, 64'd0);
        flush = 1'b1; offer(1'b1, 64'h408); tick();
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_ready", {63'd0, in_ready}, 64'd1);
        chk("fl_pc", out_pc, 64'd0);
        flush = 1'b0; out_ready = 1'b1; offer(1'b0, 64'h0); tick();
        chk("fl_dropped", {63'd0, out_valid}, 64'd0);

        // held-operand refresh
        out_ready = 1'b0; in_rs = {5'd7, 5'd3}; rf_rdata = {64'h22, 64'h22};
        offer(1'b1, 64'h500); tick();
        chk("ref_capture", out_rs_data[127:64], 64'h22);
        offer(1'b0, 64'h0);
        fwd_en = 3'b100; fwd_rd = {5'd7, 5'd0, 5'd0}; fwd_data = {64'h55, 64'h0, 64'h0};
        tick();
`ifdef IDR_HOLD_REFRESH_EN
        chk("ref_rs2", out_rs_data[127:64], 64'h55);
`else
        chk("ref_rs2", out_rs_data[127:64], 64'h22);
`endif
        chk("ref_rs1", out_rs_data[63:0], 64'h22);
        chk("ref_pc", out_pc, 64'h500);
        fwd_en = 3'b000;

        // mid-operation reset discards both entries
        offer(1'b1, 64'h600); tick();
        chk("mr_full", {63'd0, in_ready}, 64'd0);
        reset = 1'b0; offer(1'b0, 64'h0); tick();
        chk("mr_valid", {63'd0, out_valid}, 64'd0);
        chk("mr_ready", {63'd0, in_ready}, 64'd1);
        reset = 1'b1; out_ready = 1'b1; tick();
        chk("mr_empty", {63'd0, out_valid}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipeline_idr_stage_elastic.md
# pipeline_idr_stage_elastic

Parametrised, elastic register-read stage between instruction decode and execute. It performs its own operand forwarding: per-source compare against N forward buses with fixed priority and x0 suppression. A 2-entry skid buffer with valid/ready handshake replaces global stall/nop/flush, so decode and execute can stall independently at full throughput.

## Interface
- XLEN, 64, data/PC/immediate width
- NUM_SRC, 2, source operands per instruction (1..3)
- NUM_FWD, 3, forward buses; index 0 = highest priority (youngest producer)
- CTRL_W, 32, opaque packed control bundle width (alu_ctrl, BrType, dm ctrl, …), passed unmodified
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- flush  in  1  discard all held entries
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage can accept
- in_pc  in  XLEN  instruction PC
- in_rs  in  NUM_SRC*5  source register addresses, source i at [5i+4:5i]
- in_rs_used  in  NUM_SRC  source i is read by the instruction
- in_rd  in  5  destination register
- in_imm  in  XLEN  decoded immediate
- in_ctrl  in  CTRL_W  control bundle
- rf_rdata  in  NUM_SRC*XLEN  register-file read data for in_rs, same cycle
- fwd_en  in  NUM_FWD  forward bus k carries a valid write
- fwd_rd  in  NUM_FWD*5  forward bus destination
- fwd_data  in  NUM_FWD*XLEN  forward bus data
- out_valid  out  1  head entry valid
- out_ready  in  1  execute accepts head
- out_pc, out_rd, out_imm, out_ctrl, out_rs  out  as inputs  head entry fields
- out_rs_data  out  NUM_SRC*XLEN  resolved operands

## Operation
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- Operand resolve for source i: if ~in_rs_used[i] or rs==0 -> 0; else lowest k with fwd_en[k] & fwd_rd[k]==rs -> fwd_data[k]; else rf_rdata[i].
- Storage: MAIN (drives outputs) and SKID. States EMPTY, ONE, TWO.
- EMPTY: accept -> ONE, MAIN<=in.
- ONE: accept&pop -> ONE, MAIN<=in; accept&~pop -> TWO, SKID<=in; ~accept&pop -> EMPTY.
- TWO: pop -> ONE, MAIN<=SKID; no accept possible.
- in_ready = (state != TWO), from registered state only; out_valid = (state != EMPTY).
- flush: next state EMPTY regardless of accept/pop; same-cycle input dropped; flush beats reset-free events, reset beats flush.
- Empty/invalid entry fields drive 0 (bubble = all-zero, matching pipeline nop encoding).

## Timing
- Latency 1 cycle accept -> out_valid; throughput 1/cycle with out_ready high.
- No combinational path in_valid->in_ready or out_ready->in_ready.
- Reset (sampled low at edge): state EMPTY, out_valid 0, all out_* 0, in_ready 1 from next cycle; mid-operation reset discards both entries.
- Flush: out_valid 0 the cycle after; in_ready 1 the cycle after.
- Handshake: out_* fields stable while out_valid & ~out_ready (except refresh, see Configuration).

## Configuration
- IDR_HOLD_REFRESH_EN defined: each cycle, every held entry (MAIN, SKID) re-snoops forward buses with the same priority/x0/used rules and overwrites matching out_rs_data; a held operand updates the cycle after a matching fwd write.
- Undefined: operands frozen at capture; out_* fully stable while held.

## Test plan
- Back-to-back: 4 accepts, out_ready=1, rf_rdata=0x11 -> outputs 1 cycle later in order, in_ready never low.
- Skid: out_ready=0 two cycles with in_valid=1 -> state TWO, in_ready=0; out_ready=1 -> entries popped in order A,B, no loss/duplication.
- Forward priority: rs1=5, fwd_rd={5,5,5}, fwd_data={0xA,0xB,0xC} all enabled -> out_rs_data[0]=0xA; rs1=0 with fwd_rd=0 -> 0.
- Unused source: in_rs_used[1]=0, rf_rdata[1]=0xFF -> out_rs_data[1]=0.
- Flush in TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped input never appears.
- Refresh (macro on): held rs2=7 with out_ready=0, fwd_en[2]=1, fwd_rd=7, data=0x55 -> out_rs_data[1]=0x55 next cycle; macro off -> unchanged.
